// File: rtl/exception_sequencer.sv
// Exception/interrupt entry and eret exit sequencer for the CP0 path.
// Owns flush, stall, CP0 EPC/Cause/EXL writes and the PC redirect select.
module exception_sequencer #(
   parameter logic [31:0] VECTOR_ADDR = 32'h8000_0180
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        instr_valid,
   input  logic [31:0] pc,
   input  logic        reserved_instr,
   input  logic        overflow,
   input  logic        syscall,
   input  logic        eret,
   input  logic        int_req,
   input  logic        int_enable,
   input  logic        exl,
   input  logic [31:0] epc_in,
   output logic        flush,
   output logic        stall,
   output logic        epc_we,
   output logic [31:0] epc_data,
   output logic        cause_we,
   output logic [4:0]  cause_code,
   output logic        exl_set,
   output logic        exl_clr,
   output logic        redirect,
   output logic [31:0] redirect_pc,
   output logic        int_pending
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SAVE   = 2'd1;
   localparam logic [1:0] VECTOR = 2'd2;
   localparam logic [1:0] RETURN = 2'd3;

   logic [1:0]  state;
   logic [1:0]  state_n;
   logic [4:0]  cause_q;
   logic [31:0] epc_q;
   logic        take;
   logic        take_int;
   logic        do_eret;
   logic [4:0]  code_n;
   logic [31:0] epc_n;

   // Synchronous traps outrank the interrupt; only one event per cycle.
   always_comb begin
      take     = 1'b0;
      take_int = 1'b0;
      code_n   = 5'd0;
      epc_n    = pc;
      if (state == IDLE) begin
         priority case (1'b1)
            instr_valid & reserved_instr: begin
               take   = 1'b1;
               code_n = 5'd10;
            end
            instr_valid & overflow: begin
               take   = 1'b1;
               code_n = 5'd12;
            end
            instr_valid & syscall: begin
               take   = 1'b1;
               code_n = 5'd8;
               epc_n  = pc + 32'd4;
            end
            int_pending & int_enable & ~exl: begin
               take     = 1'b1;
               take_int = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign do_eret = (state == IDLE) & ~take
                  & instr_valid & eret & exl;

   always_comb begin
      state_n = IDLE;
      unique case (state)
         IDLE: begin
            if (take)
               state_n = SAVE;
            else if (do_eret)
               state_n = RETURN;
         end
         SAVE:    state_n = VECTOR;
         VECTOR:  state_n = IDLE;
         RETURN:  state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         int_pending <= 1'b0;
         cause_q     <= 5'd0;
         epc_q       <= 32'd0;
      end else begin
         state <= state_n;
         if (take) begin
            cause_q <= code_n;
            epc_q   <= epc_n;
         end
         // A live request re-latches even while the interrupt is being taken.
         if (int_req)
            int_pending <= 1'b1;
         else if (take_int)
            int_pending <= 1'b0;
      end
   end

   assign flush       = take;
   assign stall       = (state != IDLE);
   assign epc_we      = (state == SAVE);
   assign cause_we    = (state == SAVE);
   assign exl_set     = (state == SAVE);
   assign exl_clr     = (state == RETURN);
   assign redirect    = (state == VECTOR) | (state == RETURN);
   assign epc_data    = epc_q;
   assign cause_code  = (state == SAVE) ? cause_q : 5'd0;
   assign redirect_pc = (state == VECTOR) ? VECTOR_ADDR :
                        (state == RETURN) ? epc_in : 32'd0;

endmodule

// File: tb/tb_exception_sequencer.sv
// Directed bench for exception_sequencer: entry, eret, interrupt latch,
// priority, back-to-back nesting and reset abort.
module tb_exception_sequencer;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        instr_valid = 1'b0;
   logic [31:0] pc = 32'd0;
   logic        reserved_instr = 1'b0;
   logic        overflow = 1'b0;
   logic        syscall = 1'b0;
   logic        eret = 1'b0;
   logic        int_req = 1'b0;
   logic        int_enable = 1'b0;
   logic        exl = 1'b0;
   logic [31:0] epc_in = 32'd0;
   logic        flush, stall, epc_we, cause_we;
   logic        exl_set, exl_clr, redirect, int_pending;
   logic [31:0] epc_data, redirect_pc;
   logic [4:0]  cause_code;
   logic [6:0]  ctl;

   int total = 0;
   int bad = 0;

   // {flush,stall,epc_we,cause_we,exl_set,exl_clr,redirect}
   assign ctl = {flush, stall, epc_we, cause_we,
                 exl_set, exl_clr, redirect};

   localparam logic [6:0] C_IDLE = 7'b0000000;
   localparam logic [6:0] C_FLSH = 7'b1000000;
   localparam logic [6:0] C_SAVE = 7'b0111100;
   localparam logic [6:0] C_VECT = 7'b0100001;
   localparam logic [6:0] C_RETN = 7'b0100011;

   exception_sequencer dut (
      .clock(clock), .reset(reset),
      .instr_valid(instr_valid), .pc(pc),
      .reserved_instr(reserved_instr), .overflow(overflow),
      .syscall(syscall), .eret(eret),
      .int_req(int_req), .int_enable(int_enable),
      .exl(exl), .epc_in(epc_in),
      .flush(flush), .stall(stall),
      .epc_we(epc_we), .epc_data(epc_data),
      .cause_we(cause_we), .cause_code(cause_code),
      .exl_set(exl_set), .exl_clr(exl_clr),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .int_pending(int_pending)
   );

   always #5 clock = ~clock;

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic clear_instr;
      instr_valid    = 1'b0;
      reserved_instr = 1'b0;
      overflow       = 1'b0;
      syscall        = 1'b0;
      eret           = 1'b0;
   endtask

   task automatic test_reset;
      tick;
      tick;
      @(negedge clock);
      total++;
      if (ctl !== C_IDLE) begin
         bad++;
         $display("FAIL rst_ctl got=%b exp=%b", ctl, C_IDLE);
      end
      total++;
      if (int_pending !== 1'b0 || epc_data !== 32'd0) begin
         bad++;
         $display("FAIL rst_state pend=%b epc=%h exp 0/0",
                  int_pending, epc_data);
      end
      total++;
      if (redirect_pc !== 32'd0 || cause_code !== 5'd0) begin
         bad++;
         $display("FAIL rst_vals rpc=%h cause=%0d exp 0/0",
                  redirect_pc, cause_code);
      end
      tick;
      reset = 1'b0;
   endtask

   task automatic test_ri;
      instr_valid = 1'b1;
      reserved_instr = 1'b1;
      pc = 32'h0040_0010;
      @(negedge clock);
      total++;
      if (ctl !== C_FLSH) begin
         bad++;
         $display("FAIL ri_flush got=%b exp=%b", ctl, C_FLSH);
      end
      tick;
      clear_instr;
      @(negedge clock);
      total++;
      if (ctl !== C_SAVE) begin
         bad++;
         $display("FAIL ri_save got=%b exp=%b", ctl, C_SAVE);
      end
      total++;
      if (epc_data !== 32'h0040_0010 || cause_code !== 5'd10) begin
         bad++;
         $display("FAIL ri_regs epc=%h cause=%0d exp 00400010/10",
                  epc_data, cause_code);
      end
      tick;
      @(negedge clock);
      total++;
      if (ctl !== C_VECT || redirect_pc !== 32'h8000_0180) begin
         bad++;
         $display("FAIL ri_vector ctl=%b rpc=%h exp %b/80000180",
                  ctl, redirect_pc, C_VECT);
      end
      tick;
      @(negedge clock);
      total++;
      if (ctl !== C_IDLE || epc_data !== 32'h0040_0010) begin
         bad++;
         $display("FAIL ri_idle ctl=%b epc=%h exp 0/00400010",
                  ctl, epc_data);
      end
      tick;
   endtask

   task automatic test_syscall_wrap;
      instr_valid = 1'b1;
      syscall = 1'b1;
      pc = 32'hFFFF_FFFC;
      @(negedge clock);
      total++;
      if (ctl !== C_FLSH) begin
         bad++;
         $display("FAIL sys_flush got=%b exp=%b", ctl, C_FLSH);
      end
      tick;
      clear_instr;
      @(negedge clock);
      total++;
      if (ctl !== C_SAVE || epc_data !== 32'd0 ||
          cause_code !== 5'd8) begin
         bad++;
         $display("FAIL sys_save ctl=%b epc=%h cause=%0d exp %b/0/8",
                  ctl, epc_data, cause_code, C_SAVE);
      end
      tick;
      @(negedge clock);
      total++;
      if (ctl !== C_VECT) begin
         bad++;
         $display("FAIL sys_vector got=%b exp=%b", ctl, C_VECT);
      end
      tick;
      @(negedge clock);
      total++;
      if (ctl !== C_IDLE) begin
         bad++;
         $display("FAIL sys_idle got=%b exp=%b", ctl, C_IDLE);
      end
      tick;
   endtask

   task automatic test_int_masked;
      int_enable = 1'b0;
      int_req = 1'b1;
      @(negedge clock);
      total++;
      if (int_pending !== 1'b0 || ctl !== C_IDLE) begin
         bad++;
         $display("FAIL int_pre pend=%b ctl=%b exp 0/0",
                  int_pending, ctl);
      end
      tick;
      int_req = 1'b0;
      tick;
      @(negedge clock);
      total++;
      if (int_pending !== 1'b1 || ctl !== C_IDLE) begin
         bad++;
         $display("FAIL int_held pend=%b ctl=%b exp 1/0",
                  int_pending, ctl);
      end
      tick;
      int_enable = 1'b1;
      instr_valid = 1'b1;
      pc = 32'h0040_0020;
      @(negedge clock);
      total++;
      if (ctl !== C_FLSH) begin
         bad++;
         $display("FAIL int_take got=%b exp=%b", ctl, C_FLSH);
      end
      tick;
      clear_instr;
      int_enable = 1'b0;
      @(negedge clock);
      total++;
      if (cause_code !== 5'd0 || epc_data !== 32'h0040_0020 ||
          int_pending !== 1'b0 || ctl !== C_SAVE) begin
         bad++;
         $display("FAIL int_save cause=%0d epc=%h pend=%b ctl=%b",
                  cause_code, epc_data, int_pending, ctl);
      end
      tick;
      tick;
   endtask

   task automatic test_priority;
      int_enable = 1'b0;
      int_req = 1'b1;
      tick;
      int_req = 1'b0;
      int_enable = 1'b1;
      instr_valid = 1'b1;
      overflow = 1'b1;
      syscall = 1'b1;
      pc = 32'h0040_0040;
      @(negedge clock);
      total++;
      if (ctl !== C_FLSH || int_pending !== 1'b1) begin
         bad++;
         $display("FAIL pri_flush ctl=%b pend=%b exp %b/1",
                  ctl, int_pending, C_FLSH);
      end
      tick;
      clear_instr;
      exl = 1'b1;
      @(negedge clock);
      total++;
      if (cause_code !== 5'd12 || epc_data !== 32'h0040_0040 ||
          int_pending !== 1'b1) begin
         bad++;
         $display("FAIL pri_save cause=%0d epc=%h pend=%b exp 12/00400040/1",
                  cause_code, epc_data, int_pending);
      end
      tick;
      tick;
      @(negedge clock);
      total++;
      if (ctl !== C_IDLE || int_pending !== 1'b1) begin
         bad++;
         $display("FAIL pri_exl_block ctl=%b pend=%b exp 0/1",
                  ctl, int_pending);
      end
      tick;
      exl = 1'b0;
      @(negedge clock);
      total++;
      if (ctl !== C_FLSH) begin
         bad++;
         $display("FAIL pri_int_take got=%b exp=%b", ctl, C_FLSH);
      end
      tick;
      int_enable = 1'b0;
      @(negedge clock);
      total++;
      if (cause_code !== 5'd0 || int_pending !== 1'b0) begin
         bad++;
         $display("FAIL pri_int_save cause=%0d pend=%b exp 0/0",
                  cause_code, int_pending);
      end
      tick;
      tick;
   endtask

   task automatic test_eret;
      exl = 1'b1;
      instr_valid = 1'b1;
      eret = 1'b1;
      epc_in = 32'h1111_1110;
      @(negedge clock);
      total++;
      if (ctl !== C_IDLE) begin
         bad++;
         $display("FAIL eret_issue got=%b exp=%b", ctl, C_IDLE);
      end
      tick;
      clear_instr;
      epc_in = 32'h0040_0028;
      @(negedge clock);
      total++;
      if (ctl !== C_RETN || redirect_pc !== 32'h0040_0028) begin
         bad++;
         $display("FAIL eret_return ctl=%b rpc=%h exp %b/00400028",
                  ctl, redirect_pc, C_RETN);
      end
      tick;
      exl = 1'b0;
      @(negedge clock);
      total++;
      if (ctl !== C_IDLE || redirect_pc !== 32'd0) begin
         bad++;
         $display("FAIL eret_idle ctl=%b rpc=%h exp 0/0",
                  ctl, redirect_pc);
      end
      tick;
      instr_valid = 1'b1;
      eret = 1'b1;
      @(negedge clock);
      total++;
      if (ctl !== C_IDLE) begin
         bad++;
         $display("FAIL eret_noexl got=%b exp=%b", ctl, C_IDLE);
      end
      tick;
      clear_instr;
      @(negedge clock);
      total++;
      if (ctl !== C_IDLE || redirect_pc !== 32'd0) begin
         bad++;
         $display("FAIL eret_noexl_next ctl=%b rpc=%h exp 0/0",
                  ctl, redirect_pc);
      end
      tick;
   endtask

   task automatic test_back_to_back;
      instr_valid = 1'b1;
      reserved_instr = 1'b1;
      pc = 32'h0040_0060;
      tick;
      clear_instr;
      tick;
      tick;
      instr_valid = 1'b1;
      reserved_instr = 1'b1;
      pc = 32'h8000_0180;
      @(negedge clock);
      total++;
      if (ctl !== C_FLSH) begin
         bad++;
         $display("FAIL b2b_flush got=%b exp=%b", ctl, C_FLSH);
      end
      tick;
      clear_instr;
      @(negedge clock);
      total++;
      if (ctl !== C_SAVE || epc_data !== 32'h8000_0180) begin
         bad++;
         $display("FAIL b2b_save ctl=%b epc=%h exp %b/80000180",
                  ctl, epc_data, C_SAVE);
      end
      tick;
      tick;
   endtask

   task automatic test_reset_abort;
      int_enable = 1'b0;
      int_req = 1'b1;
      instr_valid = 1'b1;
      reserved_instr = 1'b1;
      pc = 32'h0040_0050;
      tick;
      clear_instr;
      int_req = 1'b0;
      @(negedge clock);
      total++;
      if (int_pending !== 1'b1 || ctl !== C_SAVE) begin
         bad++;
         $display("FAIL abort_pre pend=%b ctl=%b exp 1/%b",
                  int_pending, ctl, C_SAVE);
      end
      tick;
      reset = 1'b1;
      @(negedge clock);
      total++;
      if (ctl !== C_VECT) begin
         bad++;
         $display("FAIL abort_vector got=%b exp=%b", ctl, C_VECT);
      end
      tick;
      reset = 1'b0;
      @(negedge clock);
      total++;
      if (ctl !== C_IDLE || int_pending !== 1'b0 ||
          epc_data !== 32'd0 || redirect_pc !== 32'd0) begin
         bad++;
         $display("FAIL abort_after ctl=%b pend=%b epc=%h rpc=%h exp all 0",
                  ctl, int_pending, epc_data, redirect_pc);
      end
      tick;
   endtask

   initial begin
      test_reset;
      test_ri;
      test_syscall_wrap;
      test_int_masked;
      test_priority;
      test_eret;
      test_back_to_back;
      test_reset_abort;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/exception_sequencer.md
# exception_sequencer

Sequences exception and interrupt entry/exit for the single-cycle CPU and the CP0 coprocessor. Each cycle it takes the decoded trap sources (reserved instruction, overflow, syscall, external interrupt) and eret. It prioritises one event and drives a fixed multi-cycle sequence: flush the faulting instruction, write EPC/Cause, set or clear EXL, redirect the PC. It sits between decode/ALU and the CP0 register file and owns the PC-redirect mux select.

## Interface
- VECTOR_ADDR, 32'h8000_0180, exception handler entry address
- clock  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high; returns block to IDLE
- instr_valid  input  1  current instruction is real (not bubble/flushed)
- pc  input  32  PC of current instruction
- reserved_instr  input  1  decode found an illegal opcode
- overflow  input  1  ALU signed overflow on current instruction
- syscall  input  1  current instruction is syscall
- eret  input  1  current instruction is eret
- int_req  input  1  external interrupt request, level
- int_enable  input  1  CP0 Status[0] (IE)
- exl  input  1  CP0 Status EXL bit
- epc_in  input  32  current CP0 EPC value
- flush  output  1  kill writeback of current instruction
- stall  output  1  freeze PC and fetch
- epc_we  output  1  write epc_data into CP0 EPC
- epc_data  output  32  value for EPC
- cause_we  output  1  write cause_code into CP0 Cause[6:2]
- cause_code  output  5  exception code
- exl_set  output  1  set Status EXL
- exl_clr  output  1  clear Status EXL
- redirect  output  1  PC mux selects redirect_pc
- redirect_pc  output  32  next PC when redirect=1
- int_pending  output  1  latched interrupt awaiting service

## Operation
- States: IDLE, SAVE, VECTOR, RETURN (2-bit encoding).
- int_pending is set at any edge where int_req=1. It is cleared only on entry to SAVE with cause Int, or by reset. A request stays latched while masked.
- take (IDLE only, combinational), in priority order:
  - instr_valid & reserved_instr → code 10 (RI), EPC=pc
  - instr_valid & overflow → code 12 (Ov), EPC=pc
  - instr_valid & syscall → code 8 (Sys), EPC=pc+4 (mod 2^32)
  - int_pending & int_enable & !exl → code 0 (Int), EPC=pc (instruction not executed)
- take in IDLE: flush=1 in the same cycle. cause_code and EPC value are registered. Next state is SAVE.
- Else instr_valid & eret & exl in IDLE: flush=0. Next state is RETURN.
- eret with exl=0: no-op. The instruction completes normally and there is no state change.
- Any synchronous exception outranks eret and interrupt. eret outranks a pending interrupt, because EXL is still set in that cycle.
- SAVE: epc_we=1, cause_we=1, exl_set=1, stall=1. Next state is VECTOR.
- VECTOR: redirect=1, redirect_pc=VECTOR_ADDR, stall=1. Next state is IDLE.
- RETURN: redirect=1, redirect_pc=epc_in, exl_clr=1, stall=1. Next state is IDLE.
- In SAVE, VECTOR and RETURN, all trap inputs and eret are ignored. int_req is still latched.
- In IDLE with no event, every output except int_pending is 0. redirect_pc=0 and epc_data holds its registered value.

## Timing
- Reset: state=IDLE, int_pending=0, latched cause=0, latched EPC=0. All outputs are 0 in the cycle after reset is sampled.
- Reset asserted in SAVE, VECTOR or RETURN aborts the sequence. No further epc_we, exl_set or redirect is issued.
- Exception at cycle T:
  - T: flush
  - T+1: EPC/Cause/EXL writes, committed on the edge ending T+1
  - T+2: redirect to VECTOR_ADDR
  - T+3: IDLE, first handler instruction fetched
- eret at cycle T:
  - T+1: redirect to epc_in and exl_clr
  - T+2: IDLE
- epc_in is sampled in RETURN, so an mtc0 to EPC before eret is honoured.
- int_req pulsing for one cycle during VECTOR is serviced at the first IDLE cycle where int_enable=1 and exl=0.
- Back-to-back: an exception on the first handler instruction (T+3) is taken normally, giving a nested entry with EPC overwritten.
- flush and redirect never assert in the same cycle.

## Test plan
- RI at pc=0x00400010 → flush at T. At T+1: epc_we, epc_data=0x00400010, cause_code=10, exl_set. At T+2: redirect_pc=0x80000180. Back in IDLE at T+3.
- syscall at pc=0xFFFFFFFC → epc_data=0x00000000 (wrap), cause_code=8. Full 3-cycle sequence.
- int_req one-cycle pulse while int_enable=0 → int_pending=1 and held, no take. Raise int_enable at pc=0x00400020 → cause_code=0, epc_data=0x00400020, and int_pending=0 after the SAVE edge.
- overflow and syscall both asserted with int_pending=1 and int_enable=1 → cause_code=12. Interrupt still pending and not taken while exl=1.
- eret with exl=1 and epc_in=0x00400028 → RETURN at T+1 with redirect_pc=0x00400028 and exl_clr, then IDLE. Repeat with exl=0 → no outputs asserted.
- reset asserted during VECTOR → no redirect the next cycle, state IDLE, int_pending=0, all outputs 0.
